// File: rtl/aes_pkg.sv
// ============================================================================
//  Package : aes_pkg
//  Shared GF(2^8) helpers, MixColumns coefficients and FSM encoding for the
//  column-serial (Inv)MixColumns datapath.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NCOL = 4;

    // Only the low nibble of any (Inv)MixColumns coefficient is ever non-zero.
    localparam logic [3:0] c_mul_09 = 4'h9;
    localparam logic [3:0] c_mul_0b = 4'hb;
    localparam logic [3:0] c_mul_0d = 4'hd;
    localparam logic [3:0] c_mul_0e = 4'he;
    localparam logic [3:0] c_mul_02 = 4'h2;
    localparam logic [3:0] c_mul_03 = 4'h3;
    localparam logic [3:0] c_mul_01 = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mix_column_word.sv
// ============================================================================
//  Module : inv_mix_column_word
//  Combinational single-column (Inv)MixColumns engine; i_mode=1 selects the
//  forward matrix, i_mode=0 the inverse matrix.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_mode,
    output logic [31:0] o_col
);

    logic [7:0] w_a [NCOL];
    logic [3:0] w_k [NCOL];

    // First matrix row; every other row is this row rotated right by its index.
    assign w_k[0] = i_mode ? c_mul_02 : c_mul_0e;
    assign w_k[1] = i_mode ? c_mul_03 : c_mul_0b;
    assign w_k[2] = i_mode ? c_mul_01 : c_mul_0d;
    assign w_k[3] = i_mode ? c_mul_01 : c_mul_09;

    for (genvar j = 0; j < NCOL; j++) begin : g_byte
        assign w_a[j] = i_col[31-8*j -: 8];
    end

    for (genvar r = 0; r < NCOL; r++) begin : g_row
        assign o_col[31-8*r -: 8] = gf_mul(w_a[0], w_k[(NCOL + 0 - r) % NCOL])
                                  ^ gf_mul(w_a[1], w_k[(NCOL + 1 - r) % NCOL])
                                  ^ gf_mul(w_a[2], w_k[(NCOL + 2 - r) % NCOL])
                                  ^ gf_mul(w_a[3], w_k[(NCOL + 3 - r) % NCOL]);
    end

endmodule

`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
// ============================================================================
//  Module : inv_mix_columns_seq
//  Column-serial AES InvMixColumns over valid/ready, one column per cycle.
//  Macro INV_MIX_FWD_EN adds the fwd port (1 = forward MixColumns).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inv_mix_columns_seq #(
    parameter int NCOL  = 4,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
`ifdef INV_MIX_FWD_EN
    ,
    input  logic         fwd
`endif
);
    import aes_pkg::*;

    if (NCOL != 4 || CNT_W != 2) begin : g_bad_cfg
        $error("inv_mix_columns_seq: NCOL must be 4 and CNT_W must be 2");
    end

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_col_cnt;
    logic [127:0]       r_src;
    logic               w_accept;
    logic               w_mode;
    logic [31:0]        w_col_in;
    logic [31:0]        w_col_out;
    logic [6:0]         w_col_lsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so the block never advertises readiness in reset.
                in_ready = rst_n;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_col_cnt == CNT_W'(NCOL - 1)) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Column c lives at bits [127-32c -: 32]; for 4 columns its LSB is 32*(~c).
    assign w_col_lsb = {~r_col_cnt, 5'd0};
    assign w_col_in  = r_src[w_col_lsb +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= '0;
            r_col_cnt <= '0;
            out_state <= '0;
        end else if (w_accept) begin
            r_src     <= in_state;
            r_col_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            out_state[w_col_lsb +: 32] <= w_col_out;
            r_col_cnt                  <= r_col_cnt + CNT_W'(1);
        end
    end

`ifdef INV_MIX_FWD_EN
    logic r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_mode <= 1'b0;
        else if (w_accept) r_mode <= fwd;
    end

    assign w_mode = r_mode;
`else
    assign w_mode = 1'b0;
`endif

    inv_mix_column_word u_col (
        .i_col  (w_col_in),
        .i_mode (w_mode),
        .o_col  (w_col_out)
    );

endmodule

`default_nettype wire
